// File: rtl/phase_shift_scheduler.sv
// Round-robin scheduler that shares one phase-shift calculator between N_CH channels.
// Optional WAIT_RDY watchdog is compiled in with `define PSS_TIMEOUT_EN.
module phase_shift_scheduler #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH*32-1:0]        i_ch_freq,
  input  logic [N_CH*32-1:0]        i_ch_current_phase,
  input  logic [N_CH*32-1:0]        i_ch_desired_phase,
  input  logic [N_CH*32-1:0]        i_ch_time_from_start,
  output logic                      o_calc_start,
  output logic [31:0]               o_calc_freq,
  output logic [31:0]               o_calc_current_phase,
  output logic [31:0]               o_calc_desired_phase,
  output logic [31:0]               o_calc_time_from_start,
  input  logic [31:0]               i_calc_phase_shift,
  input  logic                      i_calc_ready,
  output logic [N_CH-1:0]           o_ack,
  output logic [31:0]               o_phase_shift_out,
  output logic [$clog2(N_CH)-1:0]   o_result_ch,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int IW = $clog2(N_CH);
  localparam int SW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_RDY,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] w_grant_idx;
  logic [IW-1:0] w_ptr_next;
  logic [SW-1:0] w_scan;
  logic          w_any_req;
  logic          w_timeout;
  logic          w_job_end;

  logic          r_calc_start;
  logic [31:0]   r_calc_freq;
  logic [31:0]   r_calc_current_phase;
  logic [31:0]   r_calc_desired_phase;
  logic [31:0]   r_calc_time_from_start;
  logic [31:0]   r_phase_shift_out;
  logic [IW-1:0] r_result_ch;

  assign w_any_req = |i_req;

  // Scan offsets from highest to lowest so the closest requester at or after
  // the pointer is the last one written and therefore wins.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_grant_idx = r_rr_ptr;
    w_scan      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_scan = {1'b0, r_rr_ptr} + SW'(i);
      if (w_scan >= SW'(N_CH)) begin
        w_scan = w_scan - SW'(N_CH);
      end
      if (i_req[w_scan[IW-1:0]]) begin
        w_grant_idx = w_scan[IW-1:0];
      end
    end
  end

  assign w_ptr_next = (r_grant == IW'(N_CH - 1)) ? '0 : r_grant + IW'(1);

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the netlist.
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_job_end   = 1'b0;
    case (r_state)
      S_IDLE:     if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE:    w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (i_calc_ready || w_timeout) begin
          w_state_nxt = S_DONE;
          w_job_end   = 1'b1;
        end
      end
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured once at grant, so later channel changes are not seen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_calc_start           <= 1'b0;
      r_calc_freq            <= '0;
      r_calc_current_phase   <= '0;
      r_calc_desired_phase   <= '0;
      r_calc_time_from_start <= '0;
      r_phase_shift_out      <= '0;
      r_result_ch            <= '0;
      r_grant                <= '0;
      r_rr_ptr               <= '0;
    end else begin
      r_calc_start <= 1'b0;
      if (r_state == S_IDLE && w_any_req) begin
        r_calc_start           <= 1'b1;
        r_grant                <= w_grant_idx;
        r_calc_freq            <= i_ch_freq[32*w_grant_idx +: 32];
        r_calc_current_phase   <= i_ch_current_phase[32*w_grant_idx +: 32];
        r_calc_desired_phase   <= i_ch_desired_phase[32*w_grant_idx +: 32];
        r_calc_time_from_start <= i_ch_time_from_start[32*w_grant_idx +: 32];
      end
      if (w_job_end) begin
        r_phase_shift_out <= i_calc_ready ? i_calc_phase_shift : '0;
        r_result_ch       <= r_grant;
      end
      if (r_state == S_DONE) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

`ifdef PSS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_err;

  assign w_timeout = (r_state == S_WAIT_RDY) && !i_calc_ready &&
                     (r_to_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_WAIT_RDY && !i_calc_ready) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_job_end) begin
        r_err <= w_timeout;
      end
    end
  end

  assign o_err = (r_state == S_DONE) && r_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign w_timeout            = 1'b0;
  assign o_err                = 1'b0;
`endif

  always_comb begin
    o_ack = '0;
    if (r_state == S_DONE) begin
      o_ack[r_grant] = 1'b1;
    end
  end

  assign o_busy                 = (r_state != S_IDLE);
  assign o_calc_start           = r_calc_start;
  assign o_calc_freq            = r_calc_freq;
  assign o_calc_current_phase   = r_calc_current_phase;
  assign o_calc_desired_phase   = r_calc_desired_phase;
  assign o_calc_time_from_start = r_calc_time_from_start;
  assign o_phase_shift_out      = r_phase_shift_out;
  assign o_result_ch            = r_result_ch;

endmodule
